uart_rx: RTL
============

# uart_rx

Serial UART receiver: the receive end of the team's 8-bit UART link, the counterpart of the transmitter. It samples the `rx` line using an oversampling tick, recovers start/8 data/optional parity/stop framing (LSB first), and presents each received byte with a one-cycle valid strobe plus parity and framing error flags. It sits between the pad-side serial input and the byte-level consumer, sharing the transmitter's baud-tick generator and parity-mode encoding.

## Interface
- `OVERSAMPLE`, 16, number of `os_tick` pulses per bit period; must be an even integer ≥ 4.
- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset (asserted when 0).
- `os_tick` input 1: one-`clk` pulse at `OVERSAMPLE` × baud rate.
- `rx` input 1: asynchronous serial line, idle high.
- `parity_mode` input 2: 00 none, 01 even, 10 odd, 11 treated as none. Sampled when a start bit is detected and held for the frame.
- `rx_data` output 8: last received byte; held until the next byte completes.
- `rx_valid` output 1: one-`clk` pulse when a frame completes.
- `parity_err` output 1: qualified by `rx_valid`; 1 means parity mismatch.
- `frame_err` output 1: qualified by `rx_valid`; 1 means the stop bit was sampled low.
- `rx_busy` output 1: high from start-bit detection until return to IDLE.

## Operation
- `rx` passes through a two-flop synchronizer (reset value 1). All decisions use the synchronized value `rx_s`.
- Tick counter `cnt` is $clog2(OVERSAMPLE) bits wide. Bit index `bit_idx` is 3 bits. The data shift register is 8 bits and fills LSB first.
- The FSM advances only on cycles where `os_tick`=1, except for the output strobes.
- IDLE: `rx_busy`=0. When `rx_s`=0 on a tick, latch `parity_mode`, clear `cnt`, go to START, and set `rx_busy`=1.
- START: increment `cnt` each tick. On the tick where `cnt`==OVERSAMPLE/2−1 (mid-bit):
  - if `rx_s`=1, treat it as a glitch: return to IDLE, `rx_busy`=0, no strobe;
  - otherwise clear `cnt`, clear `bit_idx`, and go to DATA.
- DATA: on the tick where `cnt`==OVERSAMPLE−1, store `rx_s` into bit `bit_idx` and clear `cnt`.
  - If `bit_idx`==7, go to PARITY when the latched mode is 01 or 10, otherwise go to STOP.
  - If `bit_idx`<7, increment `bit_idx`.
- PARITY: on the tick where `cnt`==OVERSAMPLE−1, record the parity error and clear `cnt`, then go to STOP.
  - Expected parity bit is ^data in even mode and ~^data in odd mode.
  - The error is set when the received bit differs from the expected bit.
- STOP: on the tick where `cnt`==OVERSAMPLE−1, sample the stop bit, then:
  - copy the shift register to `rx_data`;
  - drive `parity_err` (0 when there is no parity) and set `frame_err` = ~`rx_s`;
  - pulse `rx_valid`.
  - If `rx_s`=1, go to IDLE.
  - If `rx_s`=0 (break or framing error), go to WAIT_HIGH.
- WAIT_HIGH: `rx_busy` stays 1. Return to IDLE on the first tick with `rx_s`=1. This prevents a held-low line from re-triggering a frame.
- Error flags and `rx_data` keep their values until the next `rx_valid`.

## Timing
- Reset values: `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0, FSM=IDLE, `cnt`=0, `bit_idx`=0.
- Asserting reset mid-frame aborts the frame immediately, with no strobe. After release, the next start bit is detected from IDLE.
- `rx_valid`, `rx_data` and the error flags update in the `clk` cycle following the stop-bit sampling tick. `rx_valid` is high for exactly one `clk` cycle.
- Synchronizer latency is 2 `clk` cycles.
- Start detection happens on the first `os_tick` after `rx_s` falls. Detection jitter is at most 1 tick.
- Data bit n is sampled (OVERSAMPLE/2 + (n+1)·OVERSAMPLE) ticks after detection, i.e. at mid-bit.
- A frame without parity completes 9.5 bit periods after detection. With parity it completes 10.5 bit periods after detection.
- A new start bit is accepted on the first tick after returning to IDLE. Back-to-back frames with a single stop bit are supported.
- `os_tick` held high continuously is legal: the counter then advances every clock.

## Test plan
- Basic byte, no parity: OVERSAMPLE=16, `os_tick` every 4 `clk`, mode 00, send 0xA5 → one `rx_valid` pulse, `rx_data`=0xA5, `parity_err`=0, `frame_err`=0, `rx_busy` low afterwards.
- Parity checks: mode 01, send 0x03 with parity bit 0 → `parity_err`=0. Mode 10, send 0x03 with parity bit 0 → `parity_err`=1. Mode 01, send 0x07 with parity bit 1 → `parity_err`=0.
- Start glitch: pull `rx` low for 3 ticks, then high → no `rx_valid`, `rx_busy` back to 0, FSM in IDLE. A following 0x3C frame is received correctly.
- Framing error and break: send 0x55 with the stop bit low, then hold low for 20 bit periods → one `rx_valid` with `frame_err`=1. No further strobes until the line goes high. The next frame 0x81 is received cleanly.
- Back-to-back frames: send 0x00, 0xFF, 0x5A with single stop bits and no idle gap, mode 10 → three `rx_valid` pulses, data in order, all error flags 0.
- Reset mid-frame: assert reset during data bit 4 of 0xC3 → all outputs at reset values at once, no strobe. After release, 0x99 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/8-data/optional-parity/stop framing, LSB first.
// Presents each byte with a one-cycle valid strobe and parity/framing error flags.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       os_tick,
  input  logic       rx,
  input  logic [1:0] parity_mode,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t      state, state_next;
  logic [1:0]  sync;
  logic        rx_s;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift, shift_next;
  logic [1:0]  mode, mode_next;
  logic        par_flag, par_flag_next;
  logic        has_par_c, exp_par_c, done_c;
  logic [7:0]  rx_data_next;
  logic        rx_valid_next, parity_err_next, frame_err_next, rx_busy_next;

  assign rx_s      = sync[1];
  assign has_par_c = (mode == 2'b01) || (mode == 2'b10);
  assign exp_par_c = (mode == 2'b01) ? ^shift : ~^shift;

  // Two-flop synchronizer, idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      mode       <= '0;
      par_flag   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      mode       <= mode_next;
      par_flag   <= par_flag_next;
      rx_data    <= rx_data_next;
      rx_valid   <= rx_valid_next;
      parity_err <= parity_err_next;
      frame_err  <= frame_err_next;
      rx_busy    <= rx_busy_next;
    end
  end

  // Next-state and datapath; everything advances only on os_tick
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    mode_next     = mode;
    par_flag_next = par_flag;
    done_c        = 1'b0;
    if (os_tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            mode_next     = parity_mode;
            par_flag_next = 1'b0;
            cnt_next      = '0;
            state_next    = S_START;
          end
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            if (rx_s) begin
              state_next = S_IDLE;
            end else begin
              cnt_next     = '0;
              bit_idx_next = '0;
              state_next   = S_DATA;
            end
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == FULL_LAST) begin
            shift_next[bit_idx] = rx_s;
            cnt_next            = '0;
            if (bit_idx == 3'd7) state_next = has_par_c ? S_PARITY : S_STOP;
            else                 bit_idx_next = bit_idx + 3'd1;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt == FULL_LAST) begin
            par_flag_next = (rx_s != exp_par_c);
            cnt_next      = '0;
            state_next    = S_STOP;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == FULL_LAST) begin
            done_c     = 1'b1;
            cnt_next   = '0;
            state_next = rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Output values for the next cycle; data and flags hold between strobes
  always_comb begin
    rx_data_next    = rx_data;
    parity_err_next = parity_err;
    frame_err_next  = frame_err;
    rx_valid_next   = 1'b0;
    rx_busy_next    = (state_next != S_IDLE);
    if (done_c) begin
      rx_data_next    = shift;
      parity_err_next = par_flag;
      frame_err_next  = ~rx_s;
      rx_valid_next   = 1'b1;
    end
  end

endmodule
